// File: rtl/ps2_color_ctrl_pkg.sv
// Shared types and constants for the PS/2 colour controller.
package ps2_color_ctrl_pkg;

   // Scan-code decoder states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BRK     = 2'd1,
      EXT     = 2'd2,
      EXT_BRK = 2'd3
   } dec_state_e;

   // Colour-enable triple, red in the MSB
   typedef struct packed {
      logic r;
      logic g;
      logic b;
   } rgb_t;

   // Per-key "currently held down" bits used to suppress typematic repeats
   typedef struct packed {
      logic clr;
      logic r;
      logic g;
      logic b;
   } held_t;

   // PS/2 Set-2 prefixes
   localparam logic [7:0] PFX_BREAK = 8'hF0;
   localparam logic [7:0] PFX_EXT   = 8'hE0;

   // Default key make codes
   localparam logic [7:0] KEY_R_DEF   = 8'h2D;
   localparam logic [7:0] KEY_G_DEF   = 8'h34;
   localparam logic [7:0] KEY_B_DEF   = 8'h32;
   localparam logic [7:0] KEY_CLR_DEF = 8'h29;

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ps2_color_ctrl_if.sv
// Keyboard/frame inputs and colour/blink outputs of the colour controller.
interface ps2_color_ctrl_if;

   logic [7:0] code;
   logic       code_valid;
   logic       frame_start;
   logic       Radd;
   logic       Gadd;
   logic       Badd;
   logic       blink;
   logic       code_err;

   // Stimulus side: scan codes and frame timing in, colour state out
   modport master (
      output code, code_valid, frame_start,
      input  Radd, Gadd, Badd, blink, code_err
   );

   // Controller side
   modport slave (
      input  code, code_valid, frame_start,
      output Radd, Gadd, Badd, blink, code_err
   );

endinterface

// File: rtl/ps2_color_ctrl_blink_div.sv
// Half-period counter that inverts its output every HALF cycles.
module ps2_color_ctrl_blink_div
   import ps2_color_ctrl_pkg::*;
#(
   parameter int unsigned HALF = 5
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic toggle_o
);

   localparam int unsigned CW = cnt_width(HALF);

   logic [CW-1:0] cnt_q;
   logic          toggle_q;

   // Count 0..HALF-1, invert the output on each wrap
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         toggle_q <= 1'b0;
      end else if (cnt_q == CW'(HALF - 1)) begin
         cnt_q    <= '0;
         toggle_q <= ~toggle_q;
      end else begin
         cnt_q    <= cnt_q + CW'(1);
      end
   end

   assign toggle_o = toggle_q;

endmodule

// File: rtl/ps2_color_ctrl.sv
// Decodes PS/2 scan codes into colour-enable flags committed at frame start,
// and generates the blink square wave on the pixel clock.
module ps2_color_ctrl
   import ps2_color_ctrl_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 25000000,
   parameter int unsigned BLINK_HZ = 10,
   parameter logic [7:0]  KEY_R    = KEY_R_DEF,
   parameter logic [7:0]  KEY_G    = KEY_G_DEF,
   parameter logic [7:0]  KEY_B    = KEY_B_DEF,
   parameter logic [7:0]  KEY_CLR  = KEY_CLR_DEF
) (
   input  logic              vga_clk,
   input  logic              reset,
   ps2_color_ctrl_if.slave   bus
);

   localparam int unsigned HALF = CLK_HZ / (2 * BLINK_HZ);

   dec_state_e state_q;
   logic       err_q;
   rgb_t       pend_q, pend_d;
   rgb_t       rgb_q;
   held_t      held_q, held_d;
   logic       is_pfx;
   logic       make_evt;
   logic       brk_evt;

   // Classify the incoming byte against the decoder state
   always_comb begin
      is_pfx   = (bus.code == PFX_BREAK) || (bus.code == PFX_EXT);
      make_evt = bus.code_valid && (state_q == IDLE) && !is_pfx;
      brk_evt  = bus.code_valid && (state_q == BRK)  && !is_pfx;
   end

   // Pending/held update: first make of a key toggles, repeats are ignored
   always_comb begin
      pend_d = pend_q;
      held_d = held_q;
      if (make_evt) begin
         if (bus.code == KEY_R) begin
            if (!held_q.r) begin
               pend_d.r = ~pend_q.r;
               held_d.r = 1'b1;
            end
         end else if (bus.code == KEY_G) begin
            if (!held_q.g) begin
               pend_d.g = ~pend_q.g;
               held_d.g = 1'b1;
            end
         end else if (bus.code == KEY_B) begin
            if (!held_q.b) begin
               pend_d.b = ~pend_q.b;
               held_d.b = 1'b1;
            end
         end else if (bus.code == KEY_CLR) begin
            if (!held_q.clr) begin
               pend_d     = '0;
               held_d.clr = 1'b1;
            end
         end
      end
      if (brk_evt) begin
         if (bus.code == KEY_R)   held_d.r   = 1'b0;
         if (bus.code == KEY_G)   held_d.g   = 1'b0;
         if (bus.code == KEY_B)   held_d.b   = 1'b0;
         if (bus.code == KEY_CLR) held_d.clr = 1'b0;
      end
   end

   // Prefix decoder FSM with one-cycle error pulse on illegal prefix bytes
   always_ff @(posedge vga_clk) begin
      if (!reset) begin
         state_q <= IDLE;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (bus.code_valid) begin
            case (state_q)
               IDLE: begin
                  if (bus.code == PFX_BREAK)    state_q <= BRK;
                  else if (bus.code == PFX_EXT) state_q <= EXT;
               end
               BRK: begin
                  state_q <= IDLE;
                  if (is_pfx) err_q <= 1'b1;
               end
               EXT: begin
                  if (bus.code == PFX_BREAK) begin
                     state_q <= EXT_BRK;
                  end else if (bus.code == PFX_EXT) begin
                     err_q <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                  end
               end
               EXT_BRK: begin
                  state_q <= IDLE;
                  if (is_pfx) err_q <= 1'b1;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // Flag registers; commit samples pending as it stood before this edge
   always_ff @(posedge vga_clk) begin
      if (!reset) begin
         pend_q <= '0;
         held_q <= '0;
         rgb_q  <= '0;
      end else begin
         pend_q <= pend_d;
         held_q <= held_d;
         if (bus.frame_start) rgb_q <= pend_q;
      end
   end

   ps2_color_ctrl_blink_div #(
      .HALF (HALF)
   ) u_blink (
      .clk_i    (vga_clk),
      .rst_ni   (reset),
      .toggle_o (bus.blink)
   );

   assign bus.Radd     = rgb_q.r;
   assign bus.Gadd     = rgb_q.g;
   assign bus.Badd     = rgb_q.b;
   assign bus.code_err = err_q;

endmodule

// File: tb/tb_ps2_color_ctrl.sv
// Directed bench for ps2_color_ctrl with CLK_HZ=100, BLINK_HZ=10 (HALF=5).
module tb_ps2_color_ctrl;

   logic vga_clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   ps2_color_ctrl_if bus ();

   ps2_color_ctrl #(
      .CLK_HZ   (100),
      .BLINK_HZ (10)
   ) dut (
      .vga_clk (vga_clk),
      .reset   (reset),
      .bus     (bus)
   );

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rgb();
      return {5'd0, bus.Radd, bus.Gadd, bus.Badd};
   endfunction

   // One byte strobe; called and returns on a falling edge
   task automatic send(input logic [7:0] c);
      bus.code       = c;
      bus.code_valid = 1'b1;
      @(negedge vga_clk);
      bus.code_valid = 1'b0;
   endtask

   task automatic frame();
      bus.frame_start = 1'b1;
      @(negedge vga_clk);
      bus.frame_start = 1'b0;
   endtask

   initial begin
      reset           = 1'b0;
      bus.code        = 8'h00;
      bus.code_valid  = 1'b0;
      bus.frame_start = 1'b0;

      // Reset for three edges
      repeat (3) @(negedge vga_clk);
      check("reset_rgb", rgb(), 8'h00);
      check("reset_blink", 8'(bus.blink), 8'h00);
      check("reset_err", 8'(bus.code_err), 8'h00);

      // Blink: rises on the 5th edge after release, then every 5 edges
      reset = 1'b1;
      repeat (4) @(negedge vga_clk);
      check("blink_pre_rise", 8'(bus.blink), 8'h00);
      @(negedge vga_clk);
      check("blink_rise", 8'(bus.blink), 8'h01);
      repeat (4) @(negedge vga_clk);
      check("blink_hold_high", 8'(bus.blink), 8'h01);
      @(negedge vga_clk);
      check("blink_fall", 8'(bus.blink), 8'h00);

      // Typematic repeats toggle red only once; nothing visible before frame
      send(8'h2D); send(8'h2D); send(8'h2D);
      send(8'hF0); send(8'h2D);
      check("red_no_frame", rgb(), 8'h00);
      frame();
      check("red_on", rgb(), 8'h04);
      send(8'h2D); send(8'hF0); send(8'h2D);
      frame();
      check("red_off", rgb(), 8'h00);

      // Green and blue pending until the next frame start
      send(8'h34); send(8'h32);
      @(negedge vga_clk);
      check("gb_pending", rgb(), 8'h00);
      frame();
      check("gb_commit", rgb(), 8'h03);

      // Clear back to 000
      send(8'hF0); send(8'h34); send(8'hF0); send(8'h32);
      send(8'h29); send(8'hF0); send(8'h29);
      frame();
      check("clear_commit", rgb(), 8'h00);

      // Key arriving on the frame-start cycle misses that commit
      bus.code        = 8'h2D;
      bus.code_valid  = 1'b1;
      bus.frame_start = 1'b1;
      @(negedge vga_clk);
      bus.code_valid  = 1'b0;
      bus.frame_start = 1'b0;
      check("coincident_old", rgb(), 8'h00);
      frame();
      check("coincident_next", rgb(), 8'h04);
      send(8'hF0); send(8'h2D);

      // Extended make/break sequences leave flags alone
      send(8'hE0); send(8'h2D);
      send(8'hE0); send(8'hF0); send(8'h2D);
      frame();
      check("ext_ignored", rgb(), 8'h04);

      // E0 E0 flags an error and stays extended; following byte ignored
      send(8'hE0);
      check("ext_first_no_err", 8'(bus.code_err), 8'h00);
      send(8'hE0);
      check("ext_double_err", 8'(bus.code_err), 8'h01);
      send(8'h2D);
      check("ext_err_clears", 8'(bus.code_err), 8'h00);
      frame();
      check("ext_err_no_flag", rgb(), 8'h04);

      // F0 F0: one error pulse, then a make is decoded normally
      send(8'hF0);
      send(8'hF0);
      check("brk_double_err", 8'(bus.code_err), 8'h01);
      @(negedge vga_clk);
      check("brk_err_one_cycle", 8'(bus.code_err), 8'h00);
      send(8'h2D);
      frame();
      check("make_after_err", rgb(), 8'h00);
      send(8'hF0); send(8'h2D);

      // All three on, then space clears everything
      send(8'h2D); send(8'hF0); send(8'h2D);
      send(8'h34); send(8'hF0); send(8'h34);
      send(8'h32); send(8'hF0); send(8'h32);
      frame();
      check("all_on", rgb(), 8'h07);
      send(8'h29);
      frame();
      check("space_clear", rgb(), 8'h00);
      send(8'hF0); send(8'h29);

      // Reset after F0 discards the break prefix
      send(8'hF0);
      reset = 1'b0;
      @(negedge vga_clk);
      check("mid_reset_err", 8'(bus.code_err), 8'h00);
      check("mid_reset_blink", 8'(bus.blink), 8'h00);
      reset = 1'b1;
      send(8'h2D);
      frame();
      check("make_after_reset", rgb(), 8'h04);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ps2_color_ctrl.md
Name: ps2_color_ctrl

Overview:
- Controller that sequences the RGB colour generator from keyboard input.
- Decodes PS/2 Set-2 scan-code bytes (make/break/extended) into three colour-enable flags, Radd/Gadd/Badd, with one toggle per physical key press.
- Commits flag changes only at frame start, so a frame is never drawn with mixed colour state.
- Generates the blink square wave on the pixel clock, replacing a separate slow clock domain.

Parameters:
- CLK_HZ, 25000000, vga_clk frequency in Hz.
- BLINK_HZ, 10, blink output toggle rate; half-period = CLK_HZ/(2*BLINK_HZ) cycles.
- KEY_R, 8'h2D, make code that toggles the red flag.
- KEY_G, 8'h34, make code that toggles the green flag.
- KEY_B, 8'h32, make code that toggles the blue flag.
- KEY_CLR, 8'h29, make code (space) that clears all flags.

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-low reset.
- code  in  8  scan-code byte from the PS/2 receiver, already in the vga_clk domain.
- code_valid  in  1  one-cycle strobe; code is valid in that cycle.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- Radd  out  1  committed red enable.
- Gadd  out  1  committed green enable.
- Badd  out  1  committed blue enable.
- blink  out  1  square wave at BLINK_HZ toggle rate.
- code_err  out  1  one-cycle pulse on an illegal prefix sequence.

Behaviour:
- Reset is sampled on vga_clk edges only. While reset=0, all of the following clear to 0 on every edge: Radd/Gadd/Badd, pending flags, held flags, blink, the blink counter and code_err. The decoder goes to IDLE.
- Reset mid-sequence (e.g. after F0) discards the partial sequence.
- Decoder FSM advances only on code_valid=1:
  - IDLE: F0 -> BRK; E0 -> EXT; any other code = make, processed, stay in IDLE.
  - BRK: F0 or E0 -> code_err pulse, go to IDLE; other code = break, processed, go to IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> code_err pulse, stay in EXT; other code is ignored, go to IDLE.
  - EXT_BRK: any code is ignored, go to IDLE; F0/E0 here also pulse code_err.
- Make processing, for KEY_R/G/B:
  - If the key's held bit is 0: toggle the pending flag and set held.
  - If held is already 1 (typematic repeat): no change.
- Make processing, for KEY_CLR:
  - If not held: pending flags := 000 and set held_clr.
- Unlisted make codes are ignored.
- Break processing: clear the matching held bit. Pending flags are unchanged.
- Commit: on frame_start=1, {Radd,Gadd,Badd} <= pending flags of the previous cycle; visible the cycle after the frame_start edge.
- If code_valid and frame_start coincide, the commit uses pre-update pending values. The new key effect appears at the next frame_start.
- Outputs are registered; total latency is key make -> pending in 1 cycle, then pending -> output at the next frame_start.
- Blink:
  - Counter width = clog2(CLK_HZ/(2*BLINK_HZ)).
  - Counter runs 0..HALF-1; at HALF-1 it wraps to 0 and blink inverts.
  - Blink is free-running and independent of frame_start.
- code_err is high for exactly one cycle per illegal byte and is never asserted in the same cycle as reset=0.

Decomposition:
- Shared package:
  - FSM state enum {IDLE, BRK, EXT, EXT_BRK}.
  - PS/2 constants PFX_BREAK=8'hF0 and PFX_EXT=8'hE0.
  - Default key-code constants.
- One natural sub-module, blink_div: a parameterised half-period counter with toggle output. It is reusable for other slow enables (e.g. cursor).
- Decoder, held/pending registers and commit logic stay in the top block.

Test Plan (CLK_HZ=100 and BLINK_HZ=10 in simulation, so HALF=5):
- Reset held low for 3 cycles, then released -> all outputs 0. Blink first rises 5 cycles after release and toggles every 5 cycles thereafter.
- Codes 2D, 2D, 2D (typematic), then F0 2D, then frame_start -> Radd=1 only; a second press (2D, F0 2D) plus frame_start -> Radd=0.
- Codes 34 then 32 with no frame_start -> outputs stay 000. Next frame_start -> Gadd=1 and Badd=1 one cycle later.
- code_valid for 2D in the same cycle as frame_start with pending=000 -> outputs stay 000. Next frame_start -> Radd=1.
- Sequences E0 2D and E0 F0 2D -> no flag change. F0 F0 -> code_err pulses once and FSM returns to IDLE. A following 2D is processed as a make.
- With pending=111 and outputs 111: code 29 then frame_start -> outputs 000. Reset asserted after an F0 -> the next 2D is treated as a make (toggles red).
